if_prefetch_stage: RTL and testbench
====================================

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, instruction/address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted requests awaiting rvalid (>=1).
REQ-004 SHALL have parameter NOOP_INSTR, default 32'h00000013, instruction driven when no valid entry.
REQ-005 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port instr_req_o  output  1  memory request, held until instr_gnt_i.
REQ-008 SHALL have port instr_addr_o  output  WORD_WIDTH  request address, stable while instr_req_o high and no grant.
REQ-009 SHALL have port instr_gnt_i  input  1  request accepted this cycle.
REQ-010 SHALL have port instr_rvalid_i  input  1  instr_rdata_i valid this cycle, in request order.
REQ-011 SHALL have port instr_rdata_i  input  WORD_WIDTH  fetched instruction.
REQ-012 SHALL have port fetch_en_i  input  1  allows new requests.
REQ-013 SHALL have port pc_start_address_i  input  WORD_WIDTH  fetch address loaded at reset.
REQ-014 SHALL have port branch_i  input  1  redirect request (taken branch/jump).
REQ-015 SHALL have port branch_target_i  input  WORD_WIDTH  redirect address.
REQ-016 SHALL have port id_ready_i  input  1  ID accepts instruction this cycle (low = hazard stall).
REQ-017 SHALL have port instr_valid_o  output  1  FIFO head valid.
REQ-018 SHALL have port instruction_o  output  WORD_WIDTH  FIFO head instruction, NOOP_INSTR when invalid.
REQ-019 SHALL have port program_count_o  output  WORD_WIDTH  PC of FIFO head.
REQ-020 SHALL have port pc_plus4_o  output  WORD_WIDTH  program_count_o + 4, modulo 2^WORD_WIDTH.

Function
REQ-021 SHALL keep fetch_addr register; instr_addr_o = fetch_addr.
REQ-022 SHALL drive instr_req_o when fetch_en_i, no branch_i, and fifo_count + outstanding < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
REQ-023 SHALL on grant (req & gnt) increment fetch_addr by 4 (wrap) and outstanding.
REQ-024 SHALL decrement outstanding on each instr_rvalid_i; grant and rvalid same cycle leave it unchanged.
REQ-025 SHALL write each non-discarded rvalid into FIFO with its PC (tracked by separate resp_pc register, +4 per write).
REQ-026 SHALL pop FIFO head when instr_valid_o & id_ready_i; push and pop same cycle SHALL be allowed when full or empty-with-bypass not required (no bypass: rvalid data visible next cycle).
REQ-027 SHALL, on branch_i, clear FIFO, set fetch_addr and resp_pc to branch_target_i, set discard counter = outstanding (minus 1 if rvalid same cycle), and suppress instr_req_o that cycle.
REQ-028 SHALL drop rvalid data while discard counter nonzero, decrementing it; such data never enters FIFO.
REQ-029 SHALL deassert instr_valid_o in the branch cycle's following cycle until first post-branch entry is written.
REQ-030 SHALL never overflow FIFO; credit rule REQ-022 guarantees space.
REQ-031 SHALL with fetch_en_i low stop issuing, still absorb outstanding responses and drain to ID.
REQ-032 SHALL ignore instr_gnt_i when instr_req_o low.

Reset
REQ-033 SHALL on rst asynchronously: fetch_addr, resp_pc = pc_start_address_i; FIFO empty; outstanding, discard = 0; instr_req_o=0, instr_valid_o=0, instruction_o=NOOP_INSTR.
REQ-034 SHALL on reset mid-transaction abandon all outstanding responses; bench SHALL not return rvalid for pre-reset grants.

Verification
REQ-035 Reset with start 0x100, fetch_en=1, gnt every cycle, rvalid one cycle later -> addresses 0x100,0x104,...; first instr_valid_o 2 cycles after first grant, program_count_o=0x100, pc_plus4_o=0x104.
REQ-036 id_ready_i=0 continuously -> exactly FIFO_DEPTH entries buffered, instr_req_o drops, no data lost; release -> in-order pop.
REQ-037 branch_i to 0x400 with 2 outstanding -> both responses discarded, FIFO empty, next request address 0x400, first valid PC 0x400.
REQ-038 gnt held low 5 cycles -> instr_req_o and instr_addr_o stable throughout.
REQ-039 fetch_addr 0xFFFFFFFC granted -> next address 0x00000000; pc_plus4_o at head 0xFFFFFFFC equals 0x0.
REQ-040 Empty FIFO -> instruction_o=NOOP_INSTR, instr_valid_o=0; grant and rvalid same cycle -> outstanding unchanged.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: issues in-order fetches under a credit limit, buffers responses
// with their PCs in a small FIFO, and discards in-flight responses after a redirect.
module if_prefetch_stage #(
  parameter int                    WORD_WIDTH      = 32,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [WORD_WIDTH-1:0] NOOP_INSTR      = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_address_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  input  logic                  id_ready_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  output logic [WORD_WIDTH-1:0] pc_plus4_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [WORD_WIDTH-1:0] fetch_addr;
  logic [WORD_WIDTH-1:0] resp_pc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         discard;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [WORD_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

  logic credit_ok;
  logic grant;
  logic push;
  logic pop;

  // Outstanding requests reserve FIFO slots, so a response always has room.
  assign credit_ok   = ((32'(count) + 32'(outstanding)) < 32'(FIFO_DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign instr_req_o  = !rst && fetch_en_i && !branch_i && credit_ok;
  assign instr_addr_o = fetch_addr;
  assign grant        = instr_req_o && instr_gnt_i;

  assign push = instr_rvalid_i && (discard == '0) && !branch_i;
  assign pop  = instr_valid_o && id_ready_i && !branch_i;

  assign instr_valid_o   = (count != '0);
  assign instruction_o   = instr_valid_o ? instr_mem[rd_ptr] : NOOP_INSTR;
  assign program_count_o = pc_mem[rd_ptr];
  assign pc_plus4_o      = program_count_o + WORD_WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr  <= pc_start_address_i;
      resp_pc     <= pc_start_address_i;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case ({grant, instr_rvalid_i && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (branch_i) begin
        fetch_addr <= branch_target_i;
        resp_pc    <= branch_target_i;
        // Everything still in flight belongs to the old path.
        discard    <= (instr_rvalid_i && (outstanding != '0)) ? outstanding - OW'(1) : outstanding;
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (grant)
          fetch_addr <= fetch_addr + WORD_WIDTH'(4);
        if (instr_rvalid_i && (discard != '0))
          discard <= discard - OW'(1);
        if (push) begin
          resp_pc <= resp_pc + WORD_WIDTH'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_rdata_i;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order memory responder (data = address + OFS).
module tb_if_prefetch_stage;

  localparam logic [31:0] NOOP = 32'h00000013;
  localparam logic [31:0] OFS  = 32'h00AB0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_en_i;
  logic [31:0] pc_start_address_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] program_count_o;
  logic [31:0] pc_plus4_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        resp_en;
  logic [31:0] pending [$];

  if_prefetch_stage dut (
    .clk                (clk),
    .rst                (rst),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_rdata_i      (instr_rdata_i),
    .fetch_en_i         (fetch_en_i),
    .pc_start_address_i (pc_start_address_i),
    .branch_i           (branch_i),
    .branch_target_i    (branch_target_i),
    .id_ready_i         (id_ready_i),
    .instr_valid_o      (instr_valid_o),
    .instruction_o      (instruction_o),
    .program_count_o    (program_count_o),
    .pc_plus4_o         (pc_plus4_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then present the next response.
  task automatic step();
    logic        g;
    logic        rv;
    logic [31:0] a;
    #1;
    g  = instr_req_o & instr_gnt_i;
    rv = instr_rvalid_i;
    a  = instr_addr_o;
    @(posedge clk);
    #1;
    if (rv && pending.size() > 0) void'(pending.pop_front());
    if (g) pending.push_back(a);
    if (resp_en && pending.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = pending[0] + OFS;
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst                = 1'b1;
    instr_rvalid_i     = 1'b0;
    pending.delete();
    pc_start_address_i = start;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_en_i = 1'b0; instr_gnt_i = 1'b0; branch_i = 1'b0;
    branch_target_i = '0; id_ready_i = 1'b1; pc_start_address_i = 32'h100;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; resp_en = 1'b0;
    #2;
    check_eq("rst_req",   32'(instr_req_o),   32'd0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_instr", instruction_o,      NOOP);
    check_eq("rst_addr",  instr_addr_o,       32'h100);

    // Streaming: grant every cycle, response one cycle later
    do_reset(32'h100);
    fetch_en_i = 1'b1; instr_gnt_i = 1'b1; resp_en = 1'b1;
    #1;
    check_eq("str_req0",  32'(instr_req_o), 32'd1);
    check_eq("str_addr0", instr_addr_o,     32'h100);
    step();
    check_eq("str_addr1",  instr_addr_o,       32'h104);
    check_eq("str_valid1", 32'(instr_valid_o), 32'd0);
    step();
    check_eq("str_valid2", 32'(instr_valid_o), 32'd1);
    check_eq("str_pc2",    program_count_o,    32'h100);
    check_eq("str_pc4_2",  pc_plus4_o,         32'h104);
    check_eq("str_ins2",   instruction_o,      32'h100 + OFS);
    step();
    check_eq("str_pc3",   program_count_o,  32'h104);
    check_eq("str_addr3", instr_addr_o,     32'h10C);
    check_eq("str_req3",  32'(instr_req_o), 32'd1);
    fetch_en_i = 1'b0;
    #1;
    check_eq("fen_off_req", 32'(instr_req_o), 32'd0);

    // ID stall: FIFO fills to depth, fetching stops, then in-order drain
    do_reset(32'h100);
    fetch_en_i = 1'b1; instr_gnt_i = 1'b1; resp_en = 1'b1; id_ready_i = 1'b0;
    repeat (6) step();
    check_eq("stall_req",   32'(instr_req_o),   32'd0);
    check_eq("stall_valid", 32'(instr_valid_o), 32'd1);
    check_eq("stall_addr",  instr_addr_o,       32'h110);
    id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("drain_pc%0d", i),  program_count_o, 32'h100 + 32'(4 * i));
      check_eq($sformatf("drain_ins%0d", i), instruction_o,   32'h100 + 32'(4 * i) + OFS);
      step();
    end

    // Redirect with two responses in flight
    do_reset(32'h100);
    fetch_en_i = 1'b1; instr_gnt_i = 1'b1; resp_en = 1'b0;
    step();
    step();
    check_eq("br_credit_req", 32'(instr_req_o), 32'd0);
    branch_i = 1'b1; branch_target_i = 32'h400; resp_en = 1'b1;
    #1;
    check_eq("br_suppress", 32'(instr_req_o), 32'd0);
    step();
    branch_i = 1'b0;
    check_eq("br_valid_a", 32'(instr_valid_o), 32'd0);
    check_eq("br_ins_a",   instruction_o,      NOOP);
    step();
    check_eq("br_addr",    instr_addr_o,       32'h400);
    check_eq("br_req",     32'(instr_req_o),   32'd1);
    check_eq("br_valid_b", 32'(instr_valid_o), 32'd0);
    step();
    check_eq("br_valid_c", 32'(instr_valid_o), 32'd0);
    step();
    check_eq("br_valid_d", 32'(instr_valid_o), 32'd1);
    check_eq("br_pc",      program_count_o,    32'h400);
    check_eq("br_ins",     instruction_o,      32'h400 + OFS);

    // Grant withheld: request and address hold
    do_reset(32'h100);
    fetch_en_i = 1'b1; instr_gnt_i = 1'b0; resp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("hold_req%0d", i),  32'(instr_req_o), 32'd1);
      check_eq($sformatf("hold_addr%0d", i), instr_addr_o,     32'h100);
    end
    instr_gnt_i = 1'b1;
    step();
    check_eq("hold_release", instr_addr_o, 32'h104);

    // Address wrap at the top of the space
    do_reset(32'hFFFFFFFC);
    step();
    check_eq("wrap_addr", instr_addr_o, 32'h0);
    step();
    check_eq("wrap_valid", 32'(instr_valid_o), 32'd1);
    check_eq("wrap_pc",    program_count_o,    32'hFFFFFFFC);
    check_eq("wrap_pc4",   pc_plus4_o,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
